// File: rtl/xyt_frame_tx.sv
// -----------------------------------------------------------------------------
// xyt_frame_tx
//   Serial transmitter for packed smoothed samples {t[1:0], y[1:0], x[1:0]}.
//   Words arrive over a valid/ready handshake and are buffered in a small FIFO.
//   Each word is framed as start bit (0), 6 data bits LSB first, stop bit (1)
//   and shifted onto tx_out at CLKS_PER_BIT clocks per bit. Frames queued in
//   the FIFO go out back-to-back with no idle gap.
//
//   Optional feature: define XYT_FRAME_TX_PARITY_EN to insert an even-parity
//   bit (XOR of the 6 data bits) between the last data bit and the stop bit.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (2..255)
//   FIFO_DEPTH    input buffer entries (power of 2, >= 2)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous reset, ACTIVE HIGH (1 = reset) despite the name
//   in_valid     in_data valid this cycle
//   in_ready     FIFO can accept a word (= !full)
//   in_data      packed sample {t, y, x}
//   tx_out       registered serial line, idles high
//   tx_busy      high whenever the FSM is not idle
//   frame_count  completed frames, wraps modulo 256
// -----------------------------------------------------------------------------
module xyt_frame_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_data,
  output logic       tx_out,
  output logic       tx_busy,
  output logic [7:0] frame_count
);

  localparam int              AW           = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     PTR_ONE      = {{AW{1'b0}}, 1'b1};
  localparam logic [7:0]      TIMER_RELOAD = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_BIT     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef XYT_FRAME_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // Input FIFO. Pointers carry one extra bit so full and empty differ only in
  // the MSB; wrap-around is plain binary overflow.
  // ---------------------------------------------------------------------------
  logic [5:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic [5:0]  pop_data;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  assign pop_data   = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state is always written with non-blocking '<=' so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: the storage array is deliberately not reset; resetting the pointers
  // already makes every entry unreachable until it is rewritten.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

  // ---------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [5:0] shift_q, shift_d;
  logic [7:0] count_q, count_d;
  logic       tx_q, tx_d;
  logic       timer_done;
`ifdef XYT_FRAME_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  assign timer_done = (timer_q == 8'd0);

  // State register (tx_out is registered here too, from the next state).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      count_q   <= '0;
      tx_q      <= 1'b1;
`ifdef XYT_FRAME_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      tx_q      <= tx_d;
`ifdef XYT_FRAME_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    count_d   = count_q;
    pop       = 1'b0;
`ifdef XYT_FRAME_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    // The timer free-runs down to zero; states that advance reload it.
    if (!timer_done) timer_d = timer_q - 8'd1;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_d  = pop_data;
          timer_d  = TIMER_RELOAD;
          state_d  = S_START;
`ifdef XYT_FRAME_TX_PARITY_EN
          parity_d = ^pop_data;
`endif
        end
      end

      S_START: begin
        if (timer_done) begin
          state_d   = S_DATA;
          timer_d   = TIMER_RELOAD;
          bit_idx_d = 3'd0;
        end
      end

      S_DATA: begin
        if (timer_done) begin
          timer_d = TIMER_RELOAD;
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
`ifdef XYT_FRAME_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

`ifdef XYT_FRAME_TX_PARITY_EN
      S_PARITY: begin
        if (timer_done) begin
          state_d = S_STOP;
          timer_d = TIMER_RELOAD;
        end
      end
`endif

      S_STOP: begin
        if (timer_done) begin
          count_d = count_q + 8'd1;
          // Chain straight into the next frame when one is waiting.
          if (!fifo_empty) begin
            pop      = 1'b1;
            shift_d  = pop_data;
            timer_d  = TIMER_RELOAD;
            state_d  = S_START;
`ifdef XYT_FRAME_TX_PARITY_EN
            parity_d = ^pop_data;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: line level for the state being entered, so the registered
  // tx_out changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef XYT_FRAME_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx_out      = tx_q;
  assign tx_busy     = (state_q != S_IDLE);
  assign frame_count = count_q;

endmodule
